// File: rtl/exe_mem_issue_pkg.sv
// Shared definitions for the memory-issue stage: access-size encodings and the
// layout of one outstanding-request entry held in the response-ordering queue.
package exe_mem_issue_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Offset is sized for the widest bus (64 bits -> 8 byte lanes).
    localparam int OFF_MAX_W = 3;

    typedef struct packed {
        logic                 cancel;
        logic                 ld;
        logic [1:0]           size;
        logic                 sext;
        logic [OFF_MAX_W-1:0] offset;
        logic [4:0]           rd;
    } mem_entry_t;

    localparam int ENTRY_W    = $bits(mem_entry_t);
    localparam int CANCEL_BIT = ENTRY_W - 1;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order queue of outstanding memory requests. A mark pulse sets one flag bit
// (MARK_BIT) in every occupied slot, used to cancel everything in flight at once.
module mem_req_fifo #(
    parameter int DEPTH    = 4,
    parameter int ENTRY_W  = 13,
    parameter int MARK_BIT = ENTRY_W - 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic                       pop,
    input  logic                       mark,
    output logic [ENTRY_W-1:0]         head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [DEPTH-1:0]   slot_valid;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // A slot is occupied when its distance from the read pointer is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] rel;
        assign rel           = PTR_W'(g) - rd_ptr;
        assign slot_valid[g] = (CNT_W'(rel) < cnt);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the storage array is reset too, so in-flight entries are really
            // gone after reset rather than lingering behind cleared pointers.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples
            // pre-edge values regardless of statement order.
            for (int i = 0; i < DEPTH; i++) begin
                if (mark && slot_valid[i]) mem[i][MARK_BIT] <= 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/exe_mem_issue.sv
// Execute-stage memory issue: alignment check, bus request formation, in-order
// response tracking with flush cancel. Define MEM_ISSUE_STAT_EN for statistics counters.
module exe_mem_issue
    import exe_mem_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_ld,
    input  logic                       in_st,
    input  logic [1:0]                 in_size,
    input  logic                       in_sext,
    input  logic [31:0]                in_paddr,
    input  logic [DATA_W-1:0]          in_wdata,
    input  logic [4:0]                 in_rd,
    input  logic                       flush,
    output logic                       ale,
    output logic                       req,
    output logic                       req_wr,
    output logic [1:0]                 req_size,
    output logic [DATA_W/8-1:0]        req_wstrb,
    output logic [31:0]                req_addr,
    output logic [DATA_W-1:0]          req_wdata,
    input  logic                       req_addr_ok,
    input  logic                       data_ok,
    input  logic [DATA_W-1:0]          rdata,
    output logic                       resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [4:0]                 resp_rd,
    output logic                       resp_ld,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       proto_err,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_cancel
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic              is_mem;
    logic [3:0]        bytes;
    logic [2:0]        align_mask;
    logic              misaligned;
    logic [OFF_W-1:0]  offset;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop_head;
    logic              proto_err_q;
    mem_entry_t        push_entry;
    mem_entry_t        head;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              sign;

    assign is_mem     = in_ld | in_st;
    assign bytes      = size_bytes(in_size);
    assign align_mask = 3'(bytes - 4'd1);
    assign misaligned = |(in_paddr[2:0] & align_mask);
    assign offset     = in_paddr[OFF_W-1:0];

    // Everything outward-facing is gated by resetn so it reads 0 while held in reset.
    assign req      = resetn & in_valid & is_mem & ~misaligned & ~full & ~flush;
    assign push     = req & req_addr_ok;
    assign ale      = resetn & in_valid & is_mem & misaligned & ~flush;
    assign in_ready = resetn & ~flush & (~is_mem | misaligned | push);

    assign req_wr    = in_st;
    assign req_size  = in_size;
    assign req_addr  = in_paddr;
    assign req_wstrb = NB'((16'd1 << bytes) - 16'd1) << offset;

    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned,
        // which would otherwise infer a latch.
        req_wdata = in_wdata;
        case (size_e'(in_size))
            SZ_B:    req_wdata = {NB{in_wdata[7:0]}};
            SZ_H:    req_wdata = {(NB/2){in_wdata[15:0]}};
            SZ_W:    req_wdata = {(NB/4){in_wdata[31:0]}};
            default: ;
        endcase
    end

    assign push_entry = '{cancel: 1'b0, ld: in_ld, size: in_size, sext: in_sext,
                          offset: 3'(offset), rd: in_rd};

    mem_req_fifo #(
        .DEPTH    (DEPTH),
        .ENTRY_W  (ENTRY_W),
        .MARK_BIT (CANCEL_BIT)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .mark      (flush),
        .head      (head),
        .count     (outstanding),
        .full      (full),
        .empty     (empty)
    );

    // A flush arriving with data_ok drops the head just like an already-cancelled one.
    assign pop        = data_ok & ~empty;
    assign drop_head  = head.cancel | flush;
    assign resp_valid = resetn & pop & ~drop_head;
    assign resp_rd    = head.rd;
    assign resp_ld    = head.ld;

    always_comb begin
        shifted = rdata >> {head.offset, 3'b000};
        keep    = '1;
        sign    = 1'b0;
        case (size_e'(head.size))
            SZ_B: begin keep = DATA_W'(8'hFF);         sign = shifted[7];  end
            SZ_H: begin keep = DATA_W'(16'hFFFF);      sign = shifted[15]; end
            SZ_W: begin keep = DATA_W'(32'hFFFF_FFFF); sign = shifted[31]; end
            default: ;
        endcase
        resp_data = '0;
        if (head.ld) resp_data = (shifted & keep) | ((head.sext & sign) ? ~keep : '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              proto_err_q <= 1'b0;
        else if (data_ok && empty) proto_err_q <= 1'b1;
    end
    assign proto_err = proto_err_q;

`ifdef MEM_ISSUE_STAT_EN
    logic [31:0] issued_q;
    logic [31:0] cancel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issued_q <= '0;
            cancel_q <= '0;
        end else begin
            if (push)              issued_q <= issued_q + 32'd1;
            if (pop && drop_head)  cancel_q <= cancel_q + 32'd1;
        end
    end
    assign stat_issued = issued_q;
    assign stat_cancel = cancel_q;
`else
    assign stat_issued = '0;
    assign stat_cancel = '0;
`endif

endmodule

// File: tb/tb_exe_mem_issue.sv
// Bench for exe_mem_issue: directed scenarios on 32- and 64-bit instances plus a
// randomized run of the 32-bit instance against a queue-based behavioural model.
module tb_exe_mem_issue;

    localparam int DEPTH = 4;
`ifdef MEM_ISSUE_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ld, in_st, in_sext, flush, req_addr_ok, data_ok;
    logic [1:0]  in_size;
    logic [31:0] in_paddr;
    logic [4:0]  in_rd;
    logic [31:0] in_wdata, rdata;
    logic [63:0] in_wdata64, rdata64;

    logic        in_ready, ale, req, req_wr, resp_valid, resp_ld, proto_err;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr, req_wdata, resp_data, stat_issued, stat_cancel;
    logic [4:0]  resp_rd;
    logic [2:0]  outstanding;

    logic        w_in_ready, w_ale, w_req, w_req_wr, w_resp_valid, w_resp_ld, w_proto_err;
    logic [1:0]  w_req_size;
    logic [7:0]  w_req_wstrb;
    logic [31:0] w_req_addr, w_stat_issued, w_stat_cancel;
    logic [63:0] w_req_wdata, w_resp_data;
    logic [4:0]  w_resp_rd;
    logic [2:0]  w_outstanding;

    exe_mem_issue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_sext(in_sext),
        .in_paddr(in_paddr), .in_wdata(in_wdata), .in_rd(in_rd), .flush(flush),
        .ale(ale), .req(req), .req_wr(req_wr), .req_size(req_size),
        .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_addr_ok(req_addr_ok), .data_ok(data_ok), .rdata(rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_ld(resp_ld), .outstanding(outstanding), .proto_err(proto_err),
        .stat_issued(stat_issued), .stat_cancel(stat_cancel)
    );

    exe_mem_issue #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_sext(in_sext),
        .in_paddr(in_paddr), .in_wdata(in_wdata64), .in_rd(in_rd), .flush(flush),
        .ale(w_ale), .req(w_req), .req_wr(w_req_wr), .req_size(w_req_size),
        .req_wstrb(w_req_wstrb), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .req_addr_ok(req_addr_ok), .data_ok(data_ok), .rdata(rdata64),
        .resp_valid(w_resp_valid), .resp_data(w_resp_data), .resp_rd(w_resp_rd),
        .resp_ld(w_resp_ld), .outstanding(w_outstanding), .proto_err(w_proto_err),
        .stat_issued(w_stat_issued), .stat_cancel(w_stat_cancel)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the 32-bit instance: an ordered list of pending accesses.
    typedef struct {
        bit cancel;
        bit ld;
        int nb;
        bit sext;
        int off;
        int rd;
    } ent_t;

    ent_t        mq[$];
    bit          m_perr;
    logic [31:0] m_issued, m_cancel;

    task automatic set_idle();
        in_valid = 0; in_ld = 0; in_st = 0; in_size = 0; in_sext = 0;
        in_paddr = 0; in_rd = 0; in_wdata = 0; in_wdata64 = 0;
        flush = 0; req_addr_ok = 0; data_ok = 0; rdata = 0; rdata64 = 0;
    endtask

    task automatic drive_op(input bit ld, input bit st, input logic [1:0] size,
                            input bit sext, input logic [31:0] addr, input logic [4:0] rd);
        in_valid = 1; in_ld = ld; in_st = st; in_size = size; in_sext = sext;
        in_paddr = addr; in_rd = rd; req_addr_ok = 1;
    endtask

    task automatic apply_reset();
        set_idle();
        resetn = 0;
        mq.delete(); m_perr = 0; m_issued = 0; m_cancel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_reset();
        set_idle();
        resetn = 0;
        drive_op(1, 0, 2'd2, 0, 32'h100, 5'd1);
        data_ok = 1;
        #2;
        if (req !== 1'b0)        begin errors++; $display("FAIL rst_req: got %0b want 0", req); end
        checks++;
        if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
        checks++;
        if (outstanding !== 3'd0 || w_outstanding !== 3'd0) begin
            errors++; $display("FAIL rst_outstanding: got %0d/%0d want 0", outstanding, w_outstanding);
        end
        checks++;
        in_paddr = 32'h102;
        #1;
        if (ale !== 1'b0)        begin errors++; $display("FAIL rst_ale: got %0b want 0", ale); end
        checks++;
        if (proto_err !== 1'b0 || stat_issued !== 32'd0) begin
            errors++; $display("FAIL rst_regs: got perr=%0b issued=%0d want 0", proto_err, stat_issued);
        end
        checks++;
        apply_reset();
    endtask

    task automatic test_ld_half_sext();
        apply_reset();
        @(negedge clk);
        drive_op(1, 0, 2'd1, 1, 32'h1002, 5'd7);
        #1;
        if (req !== 1'b1 || req_wstrb !== 4'b1100 || req_wr !== 1'b0) begin
            errors++; $display("FAIL ldh_req: got req=%0b wstrb=%b wr=%0b want 1 1100 0", req, req_wstrb, req_wr);
        end
        checks++;
        @(negedge clk);
        set_idle();
        data_ok = 1; rdata = 32'h8001_0000;
        #1;
        if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_8001 || resp_rd !== 5'd7 || resp_ld !== 1'b1) begin
            errors++; $display("FAIL ldh_resp: got v=%0b data=%h rd=%0d ld=%0b want 1 ffff8001 7 1",
                               resp_valid, resp_data, resp_rd, resp_ld);
        end
        checks++;
        @(negedge clk);
        set_idle();
        #1;
        if (outstanding !== 3'd0) begin errors++; $display("FAIL ldh_drain: got %0d want 0", outstanding); end
        checks++;
    endtask

    task automatic test_st_byte();
        apply_reset();
        @(negedge clk);
        drive_op(0, 1, 2'd0, 0, 32'h1003, 5'd0);
        in_wdata = 32'h0000_00AB;
        #1;
        if (req_wstrb !== 4'b1000 || req_wdata !== 32'hABAB_ABAB || req_wr !== 1'b1 || req_addr !== 32'h1003) begin
            errors++; $display("FAIL stb_req: got wstrb=%b wdata=%h wr=%0b addr=%h want 1000 abababab 1 1003",
                               req_wstrb, req_wdata, req_wr, req_addr);
        end
        checks++;
        @(negedge clk);
        set_idle();
        data_ok = 1; rdata = 32'hDEAD_BEEF;
        #1;
        if (resp_valid !== 1'b1 || resp_data !== 32'd0 || resp_ld !== 1'b0) begin
            errors++; $display("FAIL stb_resp: got v=%0b data=%h ld=%0b want 1 0 0", resp_valid, resp_data, resp_ld);
        end
        checks++;
    endtask

    task automatic test_misaligned();
        apply_reset();
        @(negedge clk);
        drive_op(1, 0, 2'd2, 0, 32'h1002, 5'd3);
        #1;
        if (ale !== 1'b1 || req !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mis_flags: got ale=%0b req=%0b rdy=%0b want 1 0 1", ale, req, in_ready);
        end
        checks++;
        @(negedge clk);
        set_idle();
        #1;
        if (ale !== 1'b0 || outstanding !== 3'd0) begin
            errors++; $display("FAIL mis_after: got ale=%0b out=%0d want 0 0", ale, outstanding);
        end
        checks++;
    endtask

    task automatic test_full();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_op(1, 0, 2'd2, 0, 32'h100 + 32'(4 * k), 5'(k));
            #1;
            if (req !== 1'b1) begin errors++; $display("FAIL full_push%0d: got req=%0b want 1", k, req); end
            checks++;
        end
        @(negedge clk);
        drive_op(1, 0, 2'd2, 0, 32'h200, 5'd4);
        #1;
        if (req !== 1'b0 || in_ready !== 1'b0 || outstanding !== 3'd4) begin
            errors++; $display("FAIL full_stall: got req=%0b rdy=%0b out=%0d want 0 0 4", req, in_ready, outstanding);
        end
        checks++;
        @(negedge clk);
        data_ok = 1; rdata = 32'h1234_5678;
        #1;
        if (req !== 1'b0 || resp_valid !== 1'b1 || resp_rd !== 5'd0) begin
            errors++; $display("FAIL full_pop: got req=%0b v=%0b rd=%0d want 0 1 0", req, resp_valid, resp_rd);
        end
        checks++;
        @(negedge clk);
        data_ok = 0;
        #1;
        if (req !== 1'b1 || outstanding !== 3'd3) begin
            errors++; $display("FAIL full_resume: got req=%0b out=%0d want 1 3", req, outstanding);
        end
        checks++;
        @(negedge clk);
        set_idle();
        #1;
        if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", outstanding); end
        checks++;
    endtask

    task automatic test_flush();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_op(1, 0, 2'd0, 0, 32'h300 + 32'(k), 5'(k + 1));
        end
        @(negedge clk);
        set_idle();
        flush = 1;
        #1;
        if (in_ready !== 1'b0 || outstanding !== 3'd3) begin
            errors++; $display("FAIL flush_hold: got rdy=%0b out=%0d want 0 3", in_ready, outstanding);
        end
        checks++;
        @(negedge clk);
        flush = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_ok = 1;
            #1;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_pop%0d: got v=%0b want 0", k, resp_valid); end
            checks++;
        end
        @(negedge clk);
        data_ok = 0;
        #1;
        if (outstanding !== 3'd0 || stat_cancel !== (STAT_EN ? 32'd3 : 32'd0) ||
            stat_issued !== (STAT_EN ? 32'd3 : 32'd0) || proto_err !== 1'b0) begin
            errors++; $display("FAIL flush_stats: got out=%0d cancel=%0d issued=%0d perr=%0b",
                               outstanding, stat_cancel, stat_issued, proto_err);
        end
        checks++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_op(1, 0, 2'd2, 0, 32'h400 + 32'(4 * k), 5'(k + 10));
        end
        @(negedge clk);
        set_idle();
        flush = 1; data_ok = 1;
        #1;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_coincide: got v=%0b want 0", resp_valid); end
        checks++;
        @(negedge clk);
        flush = 0; data_ok = 1;
        #1;
        if (resp_valid !== 1'b0 || outstanding !== 3'd1) begin
            errors++; $display("FAIL flush_tail: got v=%0b out=%0d want 0 1", resp_valid, outstanding);
        end
        checks++;
        @(negedge clk);
        data_ok = 0;
        #1;
        if (outstanding !== 3'd0 || stat_cancel !== (STAT_EN ? 32'd5 : 32'd0)) begin
            errors++; $display("FAIL flush_final: got out=%0d cancel=%0d", outstanding, stat_cancel);
        end
        checks++;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_op(1, 0, 2'd2, 0, 32'h500 + 32'(4 * k), 5'd2);
        end
        @(negedge clk);
        set_idle();
        #2;
        resetn = 0;
        #1;
        if (outstanding !== 3'd0) begin errors++; $display("FAIL midrst_clear: got %0d want 0", outstanding); end
        checks++;
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        data_ok = 1;
        #1;
        if (resp_valid !== 1'b0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL midrst_pop: got v=%0b perr=%0b want 0 0", resp_valid, proto_err);
        end
        checks++;
        @(negedge clk);
        data_ok = 0;
        #1;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL midrst_perr: got %0b want 1", proto_err); end
        checks++;
    endtask

    task automatic test_wide_double();
        logic [63:0] val;
        apply_reset();
        @(negedge clk);
        drive_op(1, 0, 2'd3, 0, 32'h2008, 5'd9);
        #1;
        if (w_req !== 1'b1 || w_req_wstrb !== 8'hFF || w_ale !== 1'b0) begin
            errors++; $display("FAIL d64_req: got req=%0b wstrb=%h ale=%0b want 1 ff 0", w_req, w_req_wstrb, w_ale);
        end
        checks++;
        @(negedge clk);
        set_idle();
        val = {$urandom(), $urandom()};
        data_ok = 1; rdata64 = val;
        #1;
        if (w_resp_valid !== 1'b1 || w_resp_data !== val || w_resp_rd !== 5'd9) begin
            errors++; $display("FAIL d64_resp: got v=%0b data=%h rd=%0d want 1 %h 9", w_resp_valid, w_resp_data, w_resp_rd, val);
        end
        checks++;
        @(negedge clk);
        data_ok = 1;
        #1;
        if (w_proto_err !== 1'b0) begin errors++; $display("FAIL d64_perr_early: got %0b want 0", w_proto_err); end
        checks++;
        @(negedge clk);
        data_ok = 0;
        #1;
        if (w_proto_err !== 1'b1) begin errors++; $display("FAIL d64_perr: got %0b want 1", w_proto_err); end
        checks++;
    endtask

    task automatic test_random();
        int          nb, op, off, sh;
        bit          mem_op, mis, full_m, e_req, e_rdy, e_ale, e_rv;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_rd, lane_mask;
        ent_t        h;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            op          = $urandom_range(0, 2);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_ld       = (op == 1);
            in_st       = (op == 2);
            in_size     = 2'($urandom_range(0, 2));
            in_sext     = 1'($urandom_range(0, 1));
            in_rd       = 5'($urandom_range(0, 31));
            in_wdata    = $urandom();
            nb          = 1 << in_size;
            in_paddr    = $urandom();
            if ($urandom_range(0, 3) != 0) in_paddr = in_paddr & ~32'(nb - 1);
            flush       = ($urandom_range(0, 15) == 0);
            req_addr_ok = ($urandom_range(0, 3) != 0);
            data_ok     = ($urandom_range(0, 2) == 0);
            rdata       = $urandom();
            #1;
            mem_op = in_ld || in_st;
            mis    = (in_paddr % nb) != 0;
            full_m = (mq.size() == DEPTH);
            off    = int'(in_paddr % 4);
            e_req  = in_valid && mem_op && !mis && !full_m && !flush;
            e_rdy  = !flush && (!mem_op || mis || (e_req && req_addr_ok));
            e_ale  = in_valid && mem_op && mis && !flush;
            e_strb = 4'((((1 << nb) - 1) << off) & 15);
            e_wd   = 0;
            for (int k = 0; k < 4; k++) e_wd = e_wd | (((in_wdata >> (8 * (k % nb))) & 32'hFF) << (8 * k));
            if (req !== e_req || in_ready !== e_rdy || ale !== e_ale) begin
                errors++; $display("FAIL rnd_ctl cyc%0d: got req=%0b rdy=%0b ale=%0b want %0b %0b %0b",
                                   cyc, req, in_ready, ale, e_req, e_rdy, e_ale);
            end
            checks++;
            if (e_req) begin
                if (req_wstrb !== e_strb || req_wdata !== e_wd || req_addr !== in_paddr || req_wr !== in_st) begin
                    errors++; $display("FAIL rnd_bus cyc%0d: got strb=%b wd=%h want %b %h", cyc, req_wstrb, req_wdata, e_strb, e_wd);
                end
                checks++;
            end
            e_rv = 0;
            if (data_ok && mq.size() != 0) begin
                h    = mq[0];
                e_rv = !h.cancel && !flush;
                e_rd = 0;
                if (h.ld) begin
                    sh        = 8 * h.nb;
                    lane_mask = (h.nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << sh) - 1);
                    e_rd      = (rdata >> (8 * h.off)) & lane_mask;
                    if (h.sext && h.nb < 4 && e_rd[sh-1]) e_rd = e_rd | ~lane_mask;
                end
                if (e_rv && (resp_data !== e_rd || resp_rd !== 5'(h.rd) || resp_ld !== h.ld)) begin
                    errors++; $display("FAIL rnd_resp cyc%0d: got data=%h rd=%0d want %h %0d", cyc, resp_data, resp_rd, e_rd, h.rd);
                end
            end
            if (resp_valid !== e_rv) begin
                errors++; $display("FAIL rnd_rv cyc%0d: got %0b want %0b", cyc, resp_valid, e_rv);
            end
            checks++;
            if (outstanding !== 3'(mq.size()) || proto_err !== m_perr ||
                stat_issued !== (STAT_EN ? m_issued : 32'd0) || stat_cancel !== (STAT_EN ? m_cancel : 32'd0)) begin
                errors++; $display("FAIL rnd_state cyc%0d: got out=%0d perr=%0b iss=%0d can=%0d want %0d %0b %0d %0d",
                                   cyc, outstanding, proto_err, stat_issued, stat_cancel, mq.size(), m_perr, m_issued, m_cancel);
            end
            checks++;
            if (data_ok) begin
                if (mq.size() == 0) m_perr = 1;
                else begin
                    h = mq.pop_front();
                    if (h.cancel || flush) m_cancel++;
                end
            end
            if (flush) foreach (mq[i]) mq[i].cancel = 1;
            if (e_req && req_addr_ok) begin
                mq.push_back('{cancel: 0, ld: in_ld, nb: nb, sext: in_sext, off: off, rd: int'(in_rd)});
                m_issued++;
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_ld_half_sext();
        test_st_byte();
        test_misaligned();
        test_full();
        test_flush();
        test_reset_midflight();
        test_wide_double();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_mem_issue.md
EXE_MEM_ISSUE -- requirements
Module: exe_mem_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4, max outstanding requests (power of two, 2..8).
REQ-003 SHALL have ports: clk  in  1  sole clock; resetn  in  1  reset, asynchronous, active-low (one clock; reset asynchronous active-low).
REQ-004 SHALL have ports: in_valid in 1 op offered; in_ready out 1 op consumed; in_ld in 1 load; in_st in 1 store; in_size in 2 0=B,1=H,2=W,3=D (D legal only when DATA_W=64); in_sext in 1 sign-extend load; in_paddr in 32 physical address; in_wdata in DATA_W store data (LSB-aligned); in_rd in 5 load destination.
REQ-005 SHALL have ports: flush in 1 pipeline cancel (wb_ex); ale out 1 alignment exception pulse.
REQ-006 SHALL have ports: req out 1; req_wr out 1; req_size out 2; req_wstrb out DATA_W/8; req_addr out 32; req_wdata out DATA_W; req_addr_ok in 1.
REQ-007 SHALL have ports: data_ok in 1; rdata in DATA_W; resp_valid out 1; resp_data out DATA_W; resp_rd out 5; resp_ld out 1; outstanding out $clog2(DEPTH+1); proto_err out 1; stat_issued out 32; stat_cancel out 32.

Function
REQ-008 SHALL compute bytes=1<<in_size; misaligned = in_paddr & (bytes-1) nonzero.
REQ-009 SHALL drive req = in_valid & (in_ld|in_st) & ~misaligned & ~full & ~flush, combinationally, with req_wr=in_st, req_size=in_size, req_addr=in_paddr.
REQ-010 SHALL drive req_wstrb = ((1<<bytes)-1) << offset, offset = in_paddr[log2(DATA_W/8)-1:0]; req_wdata = low bytes of in_wdata replicated across the bus.
REQ-011 SHALL drive in_ready = ~flush & (~(in_ld|in_st) | misaligned | (req & req_addr_ok)).
REQ-012 SHALL drive ale = in_valid & (in_ld|in_st) & misaligned & ~flush; no request issued.
REQ-013 SHALL push {cancel=0, ld, size, sext, offset, rd} into a DEPTH-entry FIFO on req & req_addr_ok; full = outstanding==DEPTH; no push while full, even with simultaneous pop.
REQ-014 SHALL pop the head on data_ok; outstanding = push count minus pop count, updated same cycle for simultaneous push/pop.
REQ-015 SHALL, on pop of an uncancelled entry, assert resp_valid for exactly that cycle, with resp_rd/resp_ld from the entry; no backpressure.
REQ-016 SHALL form resp_data for loads as rdata >> (offset*8), truncated to size, then sign- or zero-extended to DATA_W; for stores resp_data = 0.
REQ-017 SHALL, on flush, set cancel on every valid entry the same cycle; cancelled entries pop on data_ok with resp_valid=0.
REQ-018 SHALL, when flush and data_ok coincide, drop the popped head (treated as cancelled).
REQ-019 SHALL ignore data_ok when empty and set sticky proto_err (cleared only by reset).
REQ-020 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-021 SHALL, on resetn low, asynchronously clear the FIFO, pointers, outstanding, proto_err, and counters; req, ale, in_ready and resp_valid read 0 while in reset.
REQ-022 SHALL drop in-flight entries on reset mid-operation; data_ok after reset with empty FIFO sets proto_err.

Configuration
REQ-023 SHALL, with MEM_ISSUE_STAT_EN defined, count stat_issued (+1 per push) and stat_cancel (+1 per cancelled pop), wrapping at 2^32.
REQ-024 SHALL, without MEM_ISSUE_STAT_EN, keep both stat ports, tied to 0, with no counter registers.

Structure
REQ-025 SHALL place size encodings (SZ_B/H/W/D) and the FIFO-entry struct width in the shared package/header.
REQ-026 SHALL implement the queue as one sub-module, mem_req_fifo (DEPTH, entry width parameters).

Verification
REQ-027 SHALL test: DATA_W=32, ld.h sext, paddr 0x1002, rdata 0x8001_0000 -> req_wstrb 4'b1100, resp_data 0xFFFF_8001.
REQ-028 SHALL test: st.b paddr 0x1003, in_wdata 0xAB -> req_wstrb 4'b1000, req_wdata 0xABAB_ABAB, req_wr=1.
REQ-029 SHALL test: ld.w paddr 0x1002 -> ale=1 one cycle, req=0, in_ready=1, outstanding unchanged.
REQ-030 SHALL test: DEPTH=4, five loads with addr_ok held high, no data_ok -> four pushes, fifth stalls (req=0, outstanding=4); one data_ok -> fifth issues next cycle.
REQ-031 SHALL test: three outstanding loads, flush, then three data_ok -> no resp_valid, stat_cancel=3 (macro on), outstanding=0.
REQ-032 SHALL test: DATA_W=64, ld.d paddr 0x2008 -> req_wstrb 8'hFF, resp_data equals rdata; data_ok while empty -> proto_err=1.
